// File: rtl/ram_sp_clr_if.sv
// Access bus for ram_sp_clr: write port, read port, clear request and status.
// master drives requests, slave is the RAM.
interface ram_sp_clr_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2
);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] data_in;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic              clr_req;
    logic [DATA_W-1:0] data_out;
    logic              rd_valid;
    logic              ready;
    logic              access_drop;

    modport master (
        output wr_en, wr_addr, data_in, rd_en, rd_addr, clr_req,
        input  data_out, rd_valid, ready, access_drop
    );

    modport slave (
        input  wr_en, wr_addr, data_in, rd_en, rd_addr, clr_req,
        output data_out, rd_valid, ready, access_drop
    );
endinterface

// File: rtl/ram_sp_clr.sv
// Simple-dual-port synchronous RAM with registered read, selectable
// read-during-write behaviour and a sequencer that zeroes the array.
module ram_sp_clr #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 2,
    parameter int READ_MODE = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    ram_sp_clr_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_W;

    localparam logic [0:0] S_CLEAR = 1'b0;
    localparam logic [0:0] S_READY = 1'b1;

    logic [0:0]        r_state;
    logic [ADDR_W-1:0] r_clr_cnt;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_data_out;
    logic              r_rd_valid;
    logic              r_access_drop;

    logic              w_access;
    logic              w_accept;
    logic              w_rd_go;
    logic              w_collide;
    logic [DATA_W-1:0] w_rd_data;
    logic              w_mem_we;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [DATA_W-1:0] w_mem_din;

    // Accesses only land in READY and only when no clear is requested on the same edge.
    assign w_access  = bus.wr_en | bus.rd_en;
    assign w_accept  = (r_state == S_READY) & ~bus.clr_req;
    assign w_rd_go   = w_accept & bus.rd_en;
    assign w_collide = bus.wr_en & (bus.wr_addr == bus.rd_addr);
    assign w_rd_data = (READ_MODE != 0 && w_collide) ? bus.data_in : r_mem[bus.rd_addr];

    // The clear sequencer shares the single write port with user writes.
    assign w_mem_we   = (r_state == S_CLEAR) | (w_accept & bus.wr_en);
    assign w_mem_addr = (r_state == S_CLEAR) ? r_clr_cnt : bus.wr_addr;
    assign w_mem_din  = (r_state == S_CLEAR) ? '0 : bus.data_in;

    always_ff @(posedge clk) begin
        if (w_mem_we)
            r_mem[w_mem_addr] <= w_mem_din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_CLEAR;
            r_clr_cnt     <= '0;
            r_data_out    <= '0;
            r_rd_valid    <= 1'b0;
            r_access_drop <= 1'b0;
        end else begin
            r_rd_valid    <= w_rd_go;
            r_access_drop <= w_access & ~w_accept;
            if (w_rd_go)
                r_data_out <= w_rd_data;
            case (r_state)
                S_CLEAR: begin
                    r_clr_cnt <= r_clr_cnt + 1'b1;
                    if (&r_clr_cnt)
                        r_state <= S_READY;
                end
                default: begin
                    if (bus.clr_req) begin
                        r_state   <= S_CLEAR;
                        r_clr_cnt <= '0;
                    end
                end
            endcase
        end
    end

    assign bus.data_out    = r_data_out;
    assign bus.rd_valid    = r_rd_valid;
    assign bus.ready       = (r_state == S_READY);
    assign bus.access_drop = r_access_drop;
endmodule

// File: doc/ram_sp_clr.md
# ram_sp_clr

Parametrised simple-dual-port synchronous RAM, the successor to the fixed 4x8 RAM built from cascaded 1x8 cells. It generalises word width and depth and has separate read and write ports with a one-cycle registered read. A selectable read-during-write mode and a built-in clear sequencer zero the array after reset and on request. It serves as the general storage block for the datapath exercises that follow.

## Interface
- DATA_W, 8, word width in bits (≥1)
- ADDR_W, 2, address width; DEPTH = 2**ADDR_W words (ADDR_W ≥ 1)
- READ_MODE, 0, 0 = read-first (old data on same-address collision), 1 = write-first (new data bypassed)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- wr_en  input  1  write request
- wr_addr  input  ADDR_W  write address
- data_in  input  DATA_W  write data
- rd_en  input  1  read request
- rd_addr  input  ADDR_W  read address
- clr_req  input  1  start a full-array clear (level sampled at the edge)
- data_out  output  DATA_W  registered read data, holds between reads
- rd_valid  output  1  one-cycle pulse: data_out updated this cycle
- ready  output  1  block accepts accesses
- access_drop  output  1  one-cycle pulse: a wr_en/rd_en was rejected

## Operation
- FSM states: CLEAR, READY. Clear counter clr_cnt is ADDR_W bits wide.
- Reset (rst_n=0, asynchronous):
  - data_out=0, rd_valid=0, ready=0, access_drop=0.
  - State goes to CLEAR with clr_cnt=0.
  - The array is not reset directly.
- CLEAR state:
  - Each edge writes 0 to mem[clr_cnt] and increments clr_cnt.
  - On the edge that writes DEPTH-1, ready is set and the FSM goes to READY.
  - wr_en and rd_en are ignored. Each edge with wr_en|rd_en=1 pulses access_drop=1 on the next cycle.
  - clr_req is ignored.
  - data_out holds its value.
- READY state, priority clr_req > accesses:
  - clr_req=1: go to CLEAR with clr_cnt=0 and ready=0 from this edge. Any wr_en/rd_en in the same cycle is dropped and access_drop pulses.
  - wr_en=1: mem[wr_addr] <= data_in.
  - rd_en=1: data_out <= mem[rd_addr] and rd_valid=1 next cycle. Otherwise rd_valid=0.
  - Collision (wr_en & rd_en & wr_addr==rd_addr):
    - READ_MODE=0: data_out gets the pre-write contents.
    - READ_MODE=1: data_out gets data_in.
  - Distinct addresses are fully independent; both operations complete on the same edge.
- Only the rd_addr, wr_addr and data_in bits are used. There is no out-of-range case because DEPTH = 2**ADDR_W.

## Timing
- Read latency: 1 cycle. rd_en sampled at edge N gives data_out and rd_valid valid after edge N, held until the next accepted read.
- Write: visible to a read issued on a later edge. Same-edge visibility is set by READ_MODE.
- Clear duration: DEPTH edges after rst_n deasserts or after the clr_req edge.
  - ready=1 after the DEPTH-th clear edge; first access accepted on the following edge.
  - Example, DEPTH=4: clears on edges 1–4, ready after edge 4, first access at edge 5.
- Mid-clear reset: asynchronous abort; the clear restarts from address 0 after release.
- rd_valid and access_drop are single-cycle pulses and never stick high.
- Throughput: one read plus one write per cycle in READY.

## Test plan
- Reset release, defaults (8/2/0): ready=0 for 4 edges, then ready=1; reading addresses 0–3 returns 0x00 with rd_valid pulsing once per read.
- Write 0xA5→addr1 and 0x3C→addr2, then read addr2 and addr1 -> data_out=0x3C, then 0xA5, one cycle after each rd_en; data_out holds afterwards.
- Collision: addr3=0x11, then write 0x77→addr3 with a read of addr3 on the same edge -> READ_MODE=0 gives 0x11; READ_MODE=1 gives 0x77. A subsequent read returns 0x77 in both modes.
- clr_req with wr_en (0xFF→addr0) on the same edge -> access_drop pulse, ready low 4 edges, all addresses read 0x00 afterwards.
- Access during clear: rd_en and wr_en (0x55→addr2) two edges after reset release -> access_drop pulses, rd_valid stays 0, data_out unchanged, addr2 reads 0x00 once ready.
- rst_n pulsed low mid-clear and mid-read -> outputs 0 immediately, full 4-edge clear repeats; with DATA_W=16, ADDR_W=4 the clear lasts 16 edges and 0xBEEF round-trips at addr15.
